// File: rtl/apb_regbank_pkg.sv
`default_nettype none
// ============================================================================
// apb_regbank_pkg : shared types and helpers for the APB register bank
// Rev 1.0
// ============================================================================
package apb_regbank_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       strb
    );
        return strb ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regbank_slave_wait_ctrl.sv
`default_nettype none
// ============================================================================
// apb_wait_ctrl : APB transfer FSM, wait-state counter and address latch
// Rev 1.0
// ============================================================================
module apb_wait_ctrl
    import apb_regbank_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    output logic [ADDR_W-1:0] addr_q,
    output logic              write_q,
    output logic              pready,
    output logic              complete
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        cnt     <= CNT_W'(WAIT_STATES);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Dropping psel before completion abandons the transfer.
                    if (!psel) begin
                        state <= IDLE;
                    end else if (penable) begin
                        if (cnt == '0) state <= IDLE;
                        else           cnt   <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pready   = (state == ACCESS) && (cnt == '0);
    assign complete = pready && psel && penable;

endmodule
`default_nettype wire

// File: rtl/apb_regbank_slave.sv
`default_nettype none
// ============================================================================
// apb_regbank_slave : parametrised APB completer register bank with RO status
// Rev 1.0
// ============================================================================
module apb_regbank_slave
    import apb_regbank_pkg::*;
#(
    parameter int                     DATA_W      = 16,
    parameter int                     ADDR_W      = 4,
    parameter int                     NUM_REGS    = 4,
    parameter int                     WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [DATA_W-1:0]      RESET_VAL   = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic                         pready,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pslverr,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_rdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int                STRB_W     = strb_width(DATA_W);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              complete;
    logic              ro_hit;
    logic              err;
    logic              wr_en;
    logic [DATA_W-1:0] rd_val;

    apb_wait_ctrl #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .addr_q   (addr_q),
        .write_q  (write_q),
        .pready   (pready),
        .complete (complete)
    );

    always_comb begin
        ro_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                ro_hit = RO_MASK[i];
                rd_val = RO_MASK[i] ? hw_rdata[i*DATA_W +: DATA_W]
                                    : reg_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign err     = ({1'b0, addr_q} >= NUM_REGS_W) || (write_q && ro_hit);
    assign pslverr = pready && err;
    assign prdata  = (pready && !err) ? rd_val : '0;
    assign wr_en   = complete && write_q && !err;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        if (RO_MASK[i]) begin : g_ro
            assign reg_q[i*DATA_W +: DATA_W] = '0;
        end else begin : g_rw
            logic [DATA_W-1:0] q;

            // Unstrobed lanes keep their old byte, so X on them never lands.
            always_ff @(posedge pclk or posedge preset) begin
                if (preset) begin
                    q <= RESET_VAL;
                end else if (wr_en && (addr_q == ADDR_W'(i))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        q[8*b +: 8] <= byte_merge(q[8*b +: 8], pwdata[8*b +: 8], pstrb[b]);
                    end
                end
            end

            assign reg_q[i*DATA_W +: DATA_W] = q;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse[i] <= wr_en && (addr_q == ADDR_W'(i));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank_slave.sv
`default_nettype none
// ============================================================================
// tb_apb_regbank_slave : directed self-checking bench over three configurations
// Rev 1.0
// ============================================================================
module tb_apb_regbank_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    int          sel = 0;
    int          tests = 0, fails = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration A: 16-bit, 4 regs, no wait, reg3 read-only
    logic         pready_a, pslverr_a;
    logic [15:0]  prdata_a;
    logic [63:0]  reg_q_a;
    logic [3:0]   wr_pulse_a;
    logic [63:0]  hw_a = {16'hfeed, 48'h0};
    // Configuration B: 16-bit, 4 regs, 3 wait states
    logic         pready_b, pslverr_b;
    logic [15:0]  prdata_b;
    logic [63:0]  reg_q_b;
    logic [3:0]   wr_pulse_b;
    logic [63:0]  hw_b = '0;
    // Configuration C: 32-bit, 8 regs
    logic         pready_c, pslverr_c;
    logic [31:0]  prdata_c;
    logic [255:0] reg_q_c;
    logic [7:0]   wr_pulse_c;
    logic [255:0] hw_c = '0;

    logic        psel_a, psel_b, psel_c;
    assign psel_a = psel && (sel == 0);
    assign psel_b = psel && (sel == 1);
    assign psel_c = psel && (sel == 2);

    apb_regbank_slave #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(4), .WAIT_STATES(0),
                        .RO_MASK(4'b1000), .RESET_VAL(16'h5a5a)) dut_a (
        .pclk(clk), .preset(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata[15:0]), .pstrb(pstrb[1:0]), .pready(pready_a),
        .prdata(prdata_a), .pslverr(pslverr_a), .hw_rdata(hw_a), .reg_q(reg_q_a),
        .wr_pulse(wr_pulse_a));

    apb_regbank_slave #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(4), .WAIT_STATES(3),
                        .RO_MASK(4'b0000), .RESET_VAL(16'h0000)) dut_b (
        .pclk(clk), .preset(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata[15:0]), .pstrb(pstrb[1:0]), .pready(pready_b),
        .prdata(prdata_b), .pslverr(pslverr_b), .hw_rdata(hw_b), .reg_q(reg_q_b),
        .wr_pulse(wr_pulse_b));

    apb_regbank_slave #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(8), .WAIT_STATES(0),
                        .RO_MASK(8'h00), .RESET_VAL(32'h0)) dut_c (
        .pclk(clk), .preset(rst), .psel(psel_c), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_c),
        .prdata(prdata_c), .pslverr(pslverr_c), .hw_rdata(hw_c), .reg_q(reg_q_c),
        .wr_pulse(wr_pulse_c));

    logic        cur_pready, cur_err;
    logic [31:0] cur_prdata;
    always_comb begin
        cur_pready = pready_a;
        cur_err    = pslverr_a;
        cur_prdata = {16'h0, prdata_a};
        if (sel == 1) begin
            cur_pready = pready_b;
            cur_err    = pslverr_b;
            cur_prdata = {16'h0, prdata_b};
        end else if (sel == 2) begin
            cur_pready = pready_c;
            cur_err    = pslverr_c;
            cur_prdata = prdata_c;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the completion edge with the bus idle.
    task automatic xfer(input int s, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int n);
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 1;
        while (!cur_pready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rd = cur_prdata;
        er = cur_err;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          n;
    logic [31:0] model_c [8];
    logic [3:0]  st;
    int          t0;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pready", pready_a, 0);
        check("rst_prdata", prdata_a, 0);
        check("rst_pslverr", pslverr_a, 0);
        check("rst_wr_pulse", wr_pulse_a, 0);
        check("rst_reg_q", reg_q_a, 64'h0000_5a5a_5a5a_5a5a);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write/read, zero wait states
        xfer(0, 1, 4'h0, 32'hdead, 4'b0011, rd, er, n);
        check("w0_latency", n, 1);
        check("w0_pslverr", er, 0);
        check("w0_wr_pulse", wr_pulse_a, 4'b0001);
        @(posedge clk); #1;
        check("w0_pulse_clear", wr_pulse_a, 0);
        xfer(0, 0, 4'h0, 32'h0, 4'b0000, rd, er, n);
        check("r0_latency", n, 1);
        check("r0_data", rd, 32'hdead);
        check("r0_pslverr", er, 0);

        // Byte strobes
        xfer(0, 1, 4'h1, 32'h1234, 4'b0011, rd, er, n);
        xfer(0, 1, 4'h1, 32'h4ead, 4'b0010, rd, er, n);
        xfer(0, 0, 4'h1, 32'h0, 4'b0000, rd, er, n);
        check("strb_hi_read", rd, 32'h4e34);
        xfer(0, 1, 4'h1, 32'hxxxx_xxxx, 4'b0000, rd, er, n);
        check("strb_none_pulse", wr_pulse_a, 4'b0010);
        check("strb_none_err", er, 0);
        check("strb_none_reg", reg_q_a[31:16], 16'h4e34);

        // Error responses
        xfer(0, 1, 4'h3, 32'h1111, 4'b0011, rd, er, n);
        check("ro_write_err", er, 1);
        check("ro_write_pulse", wr_pulse_a, 0);
        check("ro_write_reg_q", reg_q_a[63:48], 16'h0000);
        xfer(0, 0, 4'h3, 32'h0, 4'b0000, rd, er, n);
        check("ro_read_data", rd, 32'hfeed);
        check("ro_read_err", er, 0);
        xfer(0, 0, 4'h5, 32'h0, 4'b0000, rd, er, n);
        check("oor_read_data", rd, 0);
        check("oor_read_err", er, 1);
        xfer(0, 1, 4'h5, 32'h7777, 4'b0011, rd, er, n);
        check("oor_write_err", er, 1);
        check("oor_write_pulse", wr_pulse_a, 0);

        // Wait states
        xfer(1, 1, 4'h2, 32'hbeef, 4'b0011, rd, er, n);
        check("ws_write_latency", n, 4);
        check("ws_write_pulse", wr_pulse_b, 4'b0100);
        xfer(1, 0, 4'h2, 32'h0, 4'b0000, rd, er, n);
        check("ws_read_latency", n, 4);
        check("ws_read_data", rd, 32'hbeef);

        // Abort in access cycle 2
        sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 4'h2; pwdata = 32'h1111; pstrb = 4'b0011;
        @(posedge clk); #1;
        penable = 1;
        check("abort_ac1_pready", pready_b, 0);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_pulse", wr_pulse_b, 0);
        end
        check("abort_reg", reg_q_b[47:32], 16'hbeef);
        check("abort_pready", pready_b, 0);

        // Back-to-back writes with random strobes on the 32-bit bank
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            st = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) begin
                model_c[i][8*b +: 8] = st[b] ? 8'(32'hcafef00d >> (8*b)) : 8'h00;
            end
            xfer(2, 1, 4'(i), 32'hcafef00d, st, rd, er, n);
        end
        check("b2b_cycles", cyc - t0, 16);
        for (int i = 0; i < 8; i++) begin
            xfer(2, 0, 4'(i), 32'h0, 4'b0000, rd, er, n);
            check("b2b_readback", rd, model_c[i]);
        end

        // Reset during the access phase of a write
        sel = 0; psel = 1; penable = 0; pwrite = 1; paddr = 4'h1; pwdata = 32'habcd; pstrb = 4'b0011;
        @(posedge clk); #1;
        penable = 1;
        rst = 1;
        #1;
        check("midrst_pready", pready_a, 0);
        check("midrst_reg1", reg_q_a[31:16], 16'h5a5a);
        check("midrst_reg0", reg_q_a[15:0], 16'h5a5a);
        psel = 0; penable = 0;
        @(posedge clk); #1;
        check("midrst_pulse", wr_pulse_a, 0);
        rst = 0;
        @(posedge clk); #1;
        xfer(0, 1, 4'h1, 32'habcd, 4'b0011, rd, er, n);
        check("postrst_pulse", wr_pulse_a, 4'b0010);
        xfer(0, 0, 4'h1, 32'h0, 4'b0000, rd, er, n);
        check("postrst_read", rd, 32'habcd);
        check("postrst_latency", n, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
